// File: rtl/flow_table_arbiter_pkg.sv
// Shared widths, owner tag encodings and the in-flight read tag type
// used by flow_table_arbiter and its read tag pipeline.
package flow_table_arbiter_pkg;

  localparam int OF_FLOW_TABLE_ADDR_WIDTH  = 10;
  localparam int OF_FLOW_TABLE_ENTRY_WIDTH = 64;

  typedef enum logic {
    OF_ARB_OWNER_LKUP = 1'b0,
    OF_ARB_OWNER_SW   = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic       vld;
    arb_owner_e owner;
  } arb_tag_t;

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// Fixed-depth shift register of {valid, owner} tags that tracks which
// requester owns each read command while it is in flight in the SRAM.
module arb_rd_tag_pipe
  import flow_table_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  arb_tag_t tag_i,
  output arb_tag_t tag_o
);

  arb_tag_t [DEPTH-1:0] stage_q;
  arb_tag_t [DEPTH-1:0] stage_d;

  assign stage_d = {stage_q[DEPTH-2:0], tag_i};
  assign tag_o   = stage_q[DEPTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/flow_table_arbiter.sv
// Shares one single-port flow-table SRAM between the lookup and software paths.
// Build option FLOW_TABLE_ARB_FAIRNESS_EN: bounds software starvation; otherwise lookup has strict priority.
module flow_table_arbiter
  import flow_table_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = OF_FLOW_TABLE_ADDR_WIDTH,
  parameter int ENTRY_WIDTH = OF_FLOW_TABLE_ENTRY_WIDTH,
  parameter int RD_LATENCY  = 2,
  parameter int MAX_STREAK  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lkup_req,
  input  logic [ADDR_WIDTH-1:0]  lkup_addr,
  output logic                   lkup_gnt,
  output logic [ENTRY_WIDTH-1:0] lkup_rd_data,
  output logic                   lkup_rd_vld,
  input  logic                   sw_req,
  input  logic                   sw_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]  sw_addr,
  input  logic [ENTRY_WIDTH-1:0] sw_wr_data,
  output logic                   sw_gnt,
  output logic [ENTRY_WIDTH-1:0] sw_rd_data,
  output logic                   sw_rd_vld,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [ENTRY_WIDTH-1:0] mem_wr_data,
  input  logic [ENTRY_WIDTH-1:0] mem_rd_data
);

  localparam int TAG_DEPTH = RD_LATENCY + 1;

  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_rd_latency
    $error("flow_table_arbiter: RD_LATENCY must be within 1..8");
  end
  if (MAX_STREAK < 1 || MAX_STREAK > 255) begin : g_bad_max_streak
    $error("flow_table_arbiter: MAX_STREAK must be within 1..255");
  end

  logic sw_turn;

`ifdef FLOW_TABLE_ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  assign sw_turn = (streak_q == STREAK_W'(MAX_STREAK));

  // Counts lookup wins while software waits; any idle-software cycle forgives the debt.
  always_comb begin
    streak_d = streak_q;
    if (!sw_req || sw_gnt) begin
      streak_d = '0;
    end else if (lkup_gnt && (streak_q != STREAK_W'(MAX_STREAK))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign sw_turn = 1'b0;
`endif

  always_comb begin
    lkup_gnt = 1'b0;
    sw_gnt   = 1'b0;
    if (!reset) begin
      if (lkup_req && !(sw_req && sw_turn)) begin
        lkup_gnt = 1'b1;
      end else if (sw_req) begin
        sw_gnt = 1'b1;
      end
    end
  end

  logic                   mem_en_q,      mem_en_d;
  logic                   mem_we_q,      mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q,    mem_addr_d;
  logic [ENTRY_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

  // Address and write data hold their last value while idle to avoid needless toggling.
  always_comb begin
    mem_en_d      = lkup_gnt | sw_gnt;
    mem_we_d      = sw_gnt & ~sw_rd_wr_L;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    if (lkup_gnt) begin
      mem_addr_d = lkup_addr;
    end else if (sw_gnt) begin
      mem_addr_d    = sw_addr;
      mem_wr_data_d = sw_wr_data;
    end
  end

  arb_tag_t tag_in;
  arb_tag_t tag_out;

  always_comb begin
    tag_in.vld   = lkup_gnt | (sw_gnt & sw_rd_wr_L);
    tag_in.owner = sw_gnt ? OF_ARB_OWNER_SW : OF_ARB_OWNER_LKUP;
  end

  arb_rd_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  logic                   lkup_rd_vld_q,  lkup_rd_vld_d;
  logic [ENTRY_WIDTH-1:0] lkup_rd_data_q, lkup_rd_data_d;
  logic                   sw_rd_vld_q,    sw_rd_vld_d;
  logic [ENTRY_WIDTH-1:0] sw_rd_data_q,   sw_rd_data_d;

  always_comb begin
    lkup_rd_vld_d  = tag_out.vld && (tag_out.owner == OF_ARB_OWNER_LKUP);
    sw_rd_vld_d    = tag_out.vld && (tag_out.owner == OF_ARB_OWNER_SW);
    lkup_rd_data_d = lkup_rd_vld_d ? mem_rd_data : lkup_rd_data_q;
    sw_rd_data_d   = sw_rd_vld_d   ? mem_rd_data : sw_rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      lkup_rd_vld_q  <= 1'b0;
      lkup_rd_data_q <= '0;
      sw_rd_vld_q    <= 1'b0;
      sw_rd_data_q   <= '0;
    end else begin
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      lkup_rd_vld_q  <= lkup_rd_vld_d;
      lkup_rd_data_q <= lkup_rd_data_d;
      sw_rd_vld_q    <= sw_rd_vld_d;
      sw_rd_data_q   <= sw_rd_data_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign lkup_rd_vld  = lkup_rd_vld_q;
  assign lkup_rd_data = lkup_rd_data_q;
  assign sw_rd_vld    = sw_rd_vld_q;
  assign sw_rd_data   = sw_rd_data_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) !(lkup_gnt && sw_gnt));

endmodule

// File: tb/tb_flow_table_arbiter.sv
// Self-checking bench for flow_table_arbiter: directed scenarios plus randomized traffic
// scored against a queue-based reference (FLOW_TABLE_ARB_FAIRNESS_EN selects the expected policy).
module tb_flow_table_arbiter;

  localparam int AW  = 10;
  localparam int EW  = 64;
  localparam int LAT = 2;
  localparam int MS  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          lkup_req;
  logic [AW-1:0] lkup_addr;
  logic          lkup_gnt;
  logic [EW-1:0] lkup_rd_data;
  logic          lkup_rd_vld;
  logic          sw_req;
  logic          sw_rd_wr_L;
  logic [AW-1:0] sw_addr;
  logic [EW-1:0] sw_wr_data;
  logic          sw_gnt;
  logic [EW-1:0] sw_rd_data;
  logic          sw_rd_vld;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] mem_wr_data;
  logic [EW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  flow_table_arbiter #(
    .ADDR_WIDTH (AW), .ENTRY_WIDTH (EW), .RD_LATENCY (LAT), .MAX_STREAK (MS)
  ) dut (
    .clk (clk), .reset (reset),
    .lkup_req (lkup_req), .lkup_addr (lkup_addr), .lkup_gnt (lkup_gnt),
    .lkup_rd_data (lkup_rd_data), .lkup_rd_vld (lkup_rd_vld),
    .sw_req (sw_req), .sw_rd_wr_L (sw_rd_wr_L), .sw_addr (sw_addr),
    .sw_wr_data (sw_wr_data), .sw_gnt (sw_gnt), .sw_rd_data (sw_rd_data),
    .sw_rd_vld (sw_rd_vld), .mem_en (mem_en), .mem_we (mem_we),
    .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_rd_data (mem_rd_data)
  );

  function automatic logic [EW-1:0] pat(input int i);
    return 64'hDEAD_BEEF_0000_0000 | 64'(i);
  endfunction

  // SRAM environment: unwritten entries read back as pat(addr).
  logic [EW-1:0] env_mem  [1024];
  bit            env_wr   [1024];
  logic [EW-1:0] env_pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wr_data;
      env_wr[mem_addr]  <= 1'b1;
    end
    env_pipe[0] <= (mem_en && !mem_we) ?
                   (env_wr[mem_addr] ? env_mem[mem_addr] : pat(int'(mem_addr))) :
                   64'h0BAD_0BAD_0BAD_0BAD;
    for (int k = 1; k < LAT; k++) env_pipe[k] <= env_pipe[k-1];
  end
  assign mem_rd_data = env_pipe[LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int due; bit owner; logic [EW-1:0] data; } rd_exp_t;
  rd_exp_t       rdq[$];
  logic [EW-1:0] ref_mem [1024];
`ifdef FLOW_TABLE_ARB_FAIRNESS_EN
  int            streak;
`endif
  logic          nx_en, nx_we;
  logic [AW-1:0] nx_addr;
  logic [EW-1:0] nx_wd;

  logic          r_en, r_we, r_lv, r_sv;
  logic [AW-1:0] r_addr;
  logic [EW-1:0] r_wd, r_ld, r_sd;
  logic          x_en, x_we, x_lv, x_sv;
  logic [AW-1:0] x_addr;
  logic [EW-1:0] x_wd, x_ld, x_sd;
  logic          o_lg, o_sg, e_lg, e_sg;

  // One clock: snapshot registered outputs and their expectations, drive requests,
  // capture grants and advance the reference model.
  task automatic tick(input logic lreq, input logic [AW-1:0] la, input logic sreq,
                      input logic srw, input logic [AW-1:0] sa, input logic [EW-1:0] swd);
    rd_exp_t e;
    @(negedge clk);
    cyc++;
    r_en = mem_en; r_we = mem_we; r_addr = mem_addr; r_wd = mem_wr_data;
    r_lv = lkup_rd_vld; r_ld = lkup_rd_data; r_sv = sw_rd_vld; r_sd = sw_rd_data;
    x_en = nx_en; x_we = nx_we; x_addr = nx_addr; x_wd = nx_wd;
    x_lv = 1'b0; x_sv = 1'b0; x_ld = '0; x_sd = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e = rdq.pop_front();
      if (e.owner) begin x_sv = 1'b1; x_sd = e.data; end
      else begin x_lv = 1'b1; x_ld = e.data; end
    end
    lkup_req = lreq; lkup_addr = la; sw_req = sreq; sw_rd_wr_L = srw;
    sw_addr = sa; sw_wr_data = swd;
    #1;
    o_lg = lkup_gnt; o_sg = sw_gnt;
    e_lg = 1'b0; e_sg = 1'b0;
`ifdef FLOW_TABLE_ARB_FAIRNESS_EN
    if (lreq && sreq) begin
      if (streak >= MS) e_sg = 1'b1; else e_lg = 1'b1;
    end else if (lreq) e_lg = 1'b1;
    else if (sreq) e_sg = 1'b1;
    if (!sreq || e_sg) streak = 0;
    else if (e_lg && streak < MS) streak++;
`else
    if (lreq) e_lg = 1'b1;
    else if (sreq) e_sg = 1'b1;
`endif
    nx_en = e_lg | e_sg;
    nx_we = e_sg & ~srw;
    if (e_lg) nx_addr = la;
    else if (e_sg) begin nx_addr = sa; nx_wd = swd; end
    if (e_lg) rdq.push_back('{cyc + LAT + 2, 1'b0, ref_mem[la]});
    else if (e_sg && srw) rdq.push_back('{cyc + LAT + 2, 1'b1, ref_mem[sa]});
    else if (e_sg) ref_mem[sa] = swd;
  endtask

  task automatic idle();
    tick(1'b0, '0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic model_clear();
    rdq.delete();
    nx_en = 1'b0; nx_we = 1'b0; nx_addr = '0; nx_wd = '0;
`ifdef FLOW_TABLE_ARB_FAIRNESS_EN
    streak = 0;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wr_data !== '0) begin failures++; $display("FAIL rst_mem_wr_data got=%h exp=0", mem_wr_data); end
    checks++; if ({lkup_rd_vld, sw_rd_vld} !== 2'b00) begin failures++; $display("FAIL rst_rd_vld got=%b%b exp=00", lkup_rd_vld, sw_rd_vld); end
    checks++; if (lkup_rd_data !== '0 || sw_rd_data !== '0) begin failures++; $display("FAIL rst_rd_data got=%h/%h exp=0/0", lkup_rd_data, sw_rd_data); end
    checks++; if ({lkup_gnt, sw_gnt} !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b%b exp=00", lkup_gnt, sw_gnt); end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle();
      checks++; if (r_en !== 1'b0 || {o_lg, o_sg} !== 2'b00) begin failures++; $display("FAIL idle_after_rst en=%b gnt=%b%b exp=0/00", r_en, o_lg, o_sg); end
    end
  endtask

  task automatic test_lookup_read();
    tick(1'b1, 10'h005, 1'b0, 1'b1, '0, '0);
    checks++; if ({o_lg, o_sg} !== 2'b10) begin failures++; $display("FAIL lr_gnt got=%b%b exp=10", o_lg, o_sg); end
    idle();
    checks++; if ({r_en, r_we} !== 2'b10 || r_addr !== 10'h005) begin failures++; $display("FAIL lr_cmd got en/we=%b%b addr=%h exp=10/005", r_en, r_we, r_addr); end
    for (int k = 2; k <= 5; k++) begin
      idle();
      checks++; if (r_lv !== (k == 4)) begin failures++; $display("FAIL lr_vld rel=%0d got=%b exp=%b", k, r_lv, (k == 4)); end
      checks++; if (r_sv !== 1'b0) begin failures++; $display("FAIL lr_sw_vld rel=%0d got=%b exp=0", k, r_sv); end
      if (k == 4) begin
        checks++; if (r_ld !== 64'hDEAD_BEEF_0000_0005) begin failures++; $display("FAIL lr_data got=%h exp=deadbeef00000005", r_ld); end
      end
    end
  endtask

  task automatic test_write_then_read();
    tick(1'b0, '0, 1'b1, 1'b0, 10'h010, 64'h1234);
    checks++; if ({o_lg, o_sg} !== 2'b01) begin failures++; $display("FAIL wr_gnt got=%b%b exp=01", o_lg, o_sg); end
    tick(1'b1, 10'h010, 1'b0, 1'b1, '0, '0);
    checks++; if ({o_lg, o_sg} !== 2'b10) begin failures++; $display("FAIL wr_rd_gnt got=%b%b exp=10", o_lg, o_sg); end
    checks++; if ({r_en, r_we} !== 2'b11 || r_addr !== 10'h010 || r_wd !== 64'h1234) begin failures++; $display("FAIL wr_cmd got en/we=%b%b addr=%h wd=%h exp=11/010/1234", r_en, r_we, r_addr, r_wd); end
    idle();
    checks++; if ({r_en, r_we} !== 2'b10 || r_addr !== 10'h010) begin failures++; $display("FAIL wr_rd_cmd got en/we=%b%b addr=%h exp=10/010", r_en, r_we, r_addr); end
    for (int k = 3; k <= 5; k++) begin
      idle();
      checks++; if (r_lv !== (k == 5)) begin failures++; $display("FAIL wr_rd_vld rel=%0d got=%b exp=%b", k, r_lv, (k == 5)); end
      if (k == 5) begin
        checks++; if (r_ld !== 64'h1234) begin failures++; $display("FAIL wr_rd_data got=%h exp=1234", r_ld); end
      end
    end
  endtask

  task automatic test_interleaved();
    tick(1'b1, 10'h040, 1'b0, 1'b1, '0, '0);
    checks++; if ({o_lg, o_sg} !== 2'b10) begin failures++; $display("FAIL il_gnt0 got=%b%b exp=10", o_lg, o_sg); end
    tick(1'b0, '0, 1'b1, 1'b1, 10'h041, '0);
    checks++; if ({o_lg, o_sg} !== 2'b01) begin failures++; $display("FAIL il_gnt1 got=%b%b exp=01", o_lg, o_sg); end
    tick(1'b1, 10'h042, 1'b0, 1'b1, '0, '0);
    checks++; if ({o_lg, o_sg} !== 2'b10) begin failures++; $display("FAIL il_gnt2 got=%b%b exp=10", o_lg, o_sg); end
    for (int k = 3; k <= 7; k++) begin
      idle();
      checks++; if ({r_lv, r_sv} !== {(k == 4 || k == 6), (k == 5)}) begin failures++; $display("FAIL il_vld rel=%0d got=%b%b exp=%b%b", k, r_lv, r_sv, (k == 4 || k == 6), (k == 5)); end
      if (k == 4 || k == 6) begin
        checks++; if (r_ld !== pat(k == 4 ? 32'h40 : 32'h42)) begin failures++; $display("FAIL il_ldata rel=%0d got=%h exp=%h", k, r_ld, pat(k == 4 ? 32'h40 : 32'h42)); end
      end
      if (k == 5) begin
        checks++; if (r_sd !== pat(32'h41)) begin failures++; $display("FAIL il_sdata got=%h exp=%h", r_sd, pat(32'h41)); end
      end
    end
  endtask

  task automatic test_starvation();
    logic [AW-1:0] la;
    logic          exp_sg;
    la = 10'h030;
    for (int k = 0; k < 27; k++) begin
      tick(1'b1, la, 1'b1, 1'b1, 10'h020, '0);
`ifdef FLOW_TABLE_ARB_FAIRNESS_EN
      exp_sg = ((k % 9) == 8);
`else
      exp_sg = 1'b0;
`endif
      checks++; if ({o_lg, o_sg} !== {~exp_sg, exp_sg}) begin failures++; $display("FAIL starve_gnt rel=%0d got=%b%b exp=%b%b", k, o_lg, o_sg, ~exp_sg, exp_sg); end
      if (e_lg) la = la + 10'd1;
    end
    tick(1'b0, '0, 1'b1, 1'b1, 10'h020, '0);
    checks++; if ({o_lg, o_sg} !== 2'b01) begin failures++; $display("FAIL starve_release got=%b%b exp=01", o_lg, o_sg); end
    for (int k = 0; k < 8; k++) begin
      idle();
      checks++; if ({r_lv, r_sv} !== {x_lv, x_sv}) begin failures++; $display("FAIL starve_drain_vld got=%b%b exp=%b%b", r_lv, r_sv, x_lv, x_sv); end
      if (x_lv) begin
        checks++; if (r_ld !== x_ld) begin failures++; $display("FAIL starve_drain_ldata got=%h exp=%h", r_ld, x_ld); end
      end
      if (x_sv) begin
        checks++; if (r_sd !== x_sd) begin failures++; $display("FAIL starve_drain_sdata got=%h exp=%h", r_sd, x_sd); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    tick(1'b1, 10'h050, 1'b0, 1'b1, '0, '0);
    checks++; if (o_lg !== 1'b1) begin failures++; $display("FAIL mid_gnt0 got=%b exp=1", o_lg); end
    tick(1'b0, '0, 1'b1, 1'b1, 10'h051, '0);
    checks++; if (o_sg !== 1'b1) begin failures++; $display("FAIL mid_gnt1 got=%b exp=1", o_sg); end
    idle();
    checks++; if ({r_en, r_we} !== 2'b10 || r_addr !== 10'h051) begin failures++; $display("FAIL mid_cmd got en/we=%b%b addr=%h exp=10/051", r_en, r_we, r_addr); end
    #1 reset = 1'b1;
    model_clear();
    #1;
    checks++; if ({mem_en, mem_we, lkup_rd_vld, sw_rd_vld} !== 4'b0000) begin failures++; $display("FAIL mid_rst_ctrl got=%b%b%b%b exp=0000", mem_en, mem_we, lkup_rd_vld, sw_rd_vld); end
    checks++; if (mem_addr !== '0 || mem_wr_data !== '0) begin failures++; $display("FAIL mid_rst_cmd got addr=%h wd=%h exp=0/0", mem_addr, mem_wr_data); end
    checks++; if (lkup_rd_data !== '0 || sw_rd_data !== '0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", lkup_rd_data, sw_rd_data); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle();
      checks++; if ({r_en, r_lv, r_sv} !== 3'b000) begin failures++; $display("FAIL mid_after_rst rel=%0d got en/lv/sv=%b%b%b exp=000", k, r_en, r_lv, r_sv); end
    end
  endtask

  task automatic test_random();
    logic          lr, sr, rw;
    logic [AW-1:0] la, sa;
    logic [EW-1:0] wd;
    lr = 1'b0; sr = 1'b0; rw = 1'b1; la = '0; sa = '0; wd = '0;
    for (int n = 0; n < 420; n++) begin
      if (n < 400) begin
        if (!lr && $urandom_range(0, 15) != 0) begin lr = 1'b1; la = 10'($urandom_range(0, 15)); end
        if (!sr && $urandom_range(0, 2) == 0) begin
          sr = 1'b1; sa = 10'($urandom_range(0, 15)); rw = 1'($urandom_range(0, 1)); wd = {$urandom, $urandom};
        end
      end
      tick(lr, la, sr, rw, sa, wd);
      checks++; if ({o_lg, o_sg} !== {e_lg, e_sg}) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", cyc, o_lg, o_sg, e_lg, e_sg); end
      checks++; if (r_en !== x_en) begin failures++; $display("FAIL rnd_mem_en cyc=%0d got=%b exp=%b", cyc, r_en, x_en); end
      if (x_en) begin
        checks++; if (r_we !== x_we || r_addr !== x_addr) begin failures++; $display("FAIL rnd_cmd cyc=%0d got we=%b addr=%h exp we=%b addr=%h", cyc, r_we, r_addr, x_we, x_addr); end
        if (x_we) begin
          checks++; if (r_wd !== x_wd) begin failures++; $display("FAIL rnd_wr_data cyc=%0d got=%h exp=%h", cyc, r_wd, x_wd); end
        end
      end
      checks++; if ({r_lv, r_sv} !== {x_lv, x_sv}) begin failures++; $display("FAIL rnd_vld cyc=%0d got=%b%b exp=%b%b", cyc, r_lv, r_sv, x_lv, x_sv); end
      if (x_lv) begin
        checks++; if (r_ld !== x_ld) begin failures++; $display("FAIL rnd_ldata cyc=%0d got=%h exp=%h", cyc, r_ld, x_ld); end
      end
      if (x_sv) begin
        checks++; if (r_sd !== x_sd) begin failures++; $display("FAIL rnd_sdata cyc=%0d got=%h exp=%h", cyc, r_sd, x_sd); end
      end
      if (e_lg) lr = 1'b0;
      if (e_sg) sr = 1'b0;
    end
    checks++; if (rdq.size() != 0) begin failures++; $display("FAIL rnd_undelivered got=%0d exp=0", rdq.size()); end
  endtask

  initial begin
    reset = 1'b1;
    lkup_req = 1'b0; lkup_addr = '0; sw_req = 1'b0; sw_rd_wr_L = 1'b1;
    sw_addr = '0; sw_wr_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    model_clear();
    repeat (3) @(negedge clk);
    test_reset();
    test_lookup_read();
    test_write_then_read();
    test_interleaved();
    test_starvation();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
